player_shot: RTL and testbench

Player projectile unit: the upward-travelling counterpart of the enemy ammunition block. On a fire-button press it launches a shot from the player ship, moves it toward the top of the screen at a fixed tick rate, and detects a hit against the enemy bounding box. It emits the shot position, a hit pulse and per-pixel RGB, and sits beside the enemy-ammo block in the game top level, feeding the VGA colour mux.

---
 rtl/player_shot.sv | 214 +++++++++++++++++++++
 tb/tb_player_shot.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_shot.sv
// Player projectile: fire-button launch, upward flight on a divided tick, enemy hit detection and pixel render.
// Build macro PLAYER_SHOT_FLASH_EN: the enemy box flashes red while in HIT (otherwise HIT lasts one cycle).
module player_shot #(
    parameter int MOVE_DIV    = 250000,
    parameter int STEP        = 2,
    parameter int Y_TOP       = 3,
    parameter int SHOT_W      = 2,
    parameter int SHOT_LEN    = 16,
    parameter int ENEMY_W     = 32,
    parameter int ENEMY_H     = 24,
    parameter int FLASH_TICKS = 8,
    parameter int COOL_TICKS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_fire,
    input  logic [10:0] posX_player,
    input  logic [10:0] posY_player,
    input  logic [10:0] posX_enemy,
    input  logic [10:0] posY_enemy,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    output logic [10:0] posX_shot,
    output logic [10:0] posY_shot,
    output logic        shot_active,
    output logic        hit,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic [1:0]  dbg_state
);

    localparam int CW   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int PMAX = (FLASH_TICKS > COOL_TICKS) ? FLASH_TICKS : COOL_TICKS;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        HIT      = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [PW-1:0] phase, phase_n;
    logic [10:0]   x_q, y_q, x_n, y_n;
    logic          hit_n;
    logic [23:0]   rgb_n;

    logic          s1, s2, s3;
    logic [1:0]    vld;
    logic          armed;
    logic          fire_rise;

    // armed only after a genuine low level has been seen post-reset, so a
    // button held through reset release cannot masquerade as a new press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            vld   <= 2'b00;
            armed <= 1'b0;
        end else begin
            s1    <= btn_fire;
            s2    <= s1;
            s3    <= s2;
            vld   <= {vld[0], 1'b1};
            armed <= armed | (vld[1] & ~s2);
        end
    end

    assign fire_rise = s2 & ~s3 & armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(MOVE_DIV - 1));

    logic [11:0] x12, y12, ex12, ey12, h12, v12;
    logic        overlap, in_shot, blank;

    assign x12  = {1'b0, x_q};
    assign y12  = {1'b0, y_q};
    assign ex12 = {1'b0, posX_enemy};
    assign ey12 = {1'b0, posY_enemy};
    assign h12  = {2'b00, h_counter};
    assign v12  = {2'b00, v_counter};

    assign overlap = (x12 < ex12 + 12'(ENEMY_W)) && (ex12 < x12 + 12'(SHOT_W)) &&
                     (y12 < ey12 + 12'(ENEMY_H)) && (ey12 < y12 + 12'(SHOT_LEN));

    assign in_shot = (h12 >= x12) && (h12 < x12 + 12'(SHOT_W)) &&
                     (v12 >= y12) && (v12 < y12 + 12'(SHOT_LEN));

    assign blank = (v_counter <= 10'd2) || (h_counter <= 10'd96);

`ifdef PLAYER_SHOT_FLASH_EN
    logic in_enemy;
    assign in_enemy = (h12 >= ex12) && (h12 < ex12 + 12'(ENEMY_W)) &&
                      (v12 >= ey12) && (v12 < ey12 + 12'(ENEMY_H));
`endif

    always_comb begin
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        phase_n = phase;
        hit_n   = 1'b0;
        case (state)
            IDLE: begin
                if (fire_rise && ({1'b0, posY_player} >= 12'(Y_TOP + SHOT_LEN))) begin
                    state_n = FLYING;
                    x_n     = posX_player;
                    y_n     = posY_player - 11'(SHOT_LEN);
                end
            end
            FLYING: begin
                // a hit takes precedence over a movement tick in the same cycle
                if (overlap) begin
                    hit_n   = 1'b1;
                    state_n = HIT;
                    phase_n = '0;
                end else if (tick) begin
                    if (y12 < 12'(Y_TOP + STEP)) begin
                        state_n = COOLDOWN;
                        y_n     = '0;
                        phase_n = '0;
                    end else begin
                        y_n = y_q - 11'(STEP);
                    end
                end
            end
            HIT: begin
`ifdef PLAYER_SHOT_FLASH_EN
                if (tick) begin
                    if (phase == PW'(FLASH_TICKS - 1)) begin
                        state_n = COOLDOWN;
                        y_n     = '0;
                        phase_n = '0;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
`else
                state_n = COOLDOWN;
                y_n     = '0;
                phase_n = '0;
`endif
            end
            COOLDOWN: begin
                if (tick) begin
                    if (phase == PW'(COOL_TICKS - 1)) begin
                        state_n = IDLE;
                        phase_n = '0;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rgb_n = 24'h000000;
        if (!blank) begin
            if (state == FLYING && in_shot) begin
                rgb_n = 24'hFFFF00;
            end
`ifdef PLAYER_SHOT_FLASH_EN
            else if (state == HIT && in_enemy && !phase[0]) begin
                rgb_n = 24'hFF0000;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            phase       <= '0;
            hit         <= 1'b0;
            shot_active <= 1'b0;
            R           <= '0;
            G           <= '0;
            B           <= '0;
        end else begin
            state       <= state_n;
            x_q         <= x_n;
            y_q         <= y_n;
            phase       <= phase_n;
            hit         <= hit_n;
            shot_active <= (state_n == FLYING);
            {R, G, B}   <= rgb_n;
        end
    end

    assign posX_shot = x_q;
    assign posY_shot = y_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_player_shot.sv
// Self-checking bench for player_shot: cycle model of the shot rules plus directed scenarios.
module tb_player_shot;

    localparam int MOVE_DIV    = 4;
    localparam int STEP        = 2;
    localparam int Y_TOP       = 3;
    localparam int SHOT_W      = 2;
    localparam int SHOT_LEN    = 16;
    localparam int ENEMY_W     = 32;
    localparam int ENEMY_H     = 24;
    localparam int FLASH_TICKS = 2;
    localparam int COOL_TICKS  = 2;

    localparam int M_IDLE = 0;
    localparam int M_FLY  = 1;
    localparam int M_HIT  = 2;
    localparam int M_COOL = 3;
    localparam int YELLOW = 24'hFFFF00;
    localparam int RED    = 24'hFF0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_fire = 1'b0;
    logic [10:0] posX_player = 11'd200;
    logic [10:0] posY_player = 11'd300;
    logic [10:0] posX_enemy = 11'd600;
    logic [10:0] posY_enemy = 11'd0;
    logic [9:0]  h_counter = 10'd0;
    logic [9:0]  v_counter = 10'd0;
    logic [10:0] posX_shot, posY_shot;
    logic        shot_active, hit;
    logic [7:0]  R, G, B;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    int m_mode, m_x, m_y, m_left, m_cyc, m_hit, m_rgb;
    bit samp_q[$];
    int y_prev;

    player_shot #(
        .MOVE_DIV(MOVE_DIV), .STEP(STEP), .Y_TOP(Y_TOP), .SHOT_W(SHOT_W),
        .SHOT_LEN(SHOT_LEN), .ENEMY_W(ENEMY_W), .ENEMY_H(ENEMY_H),
        .FLASH_TICKS(FLASH_TICKS), .COOL_TICKS(COOL_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .btn_fire(btn_fire),
        .posX_player(posX_player), .posY_player(posY_player),
        .posX_enemy(posX_enemy), .posY_enemy(posY_enemy),
        .h_counter(h_counter), .v_counter(v_counter),
        .posX_shot(posX_shot), .posY_shot(posY_shot),
        .shot_active(shot_active), .hit(hit),
        .R(R), .G(G), .B(B), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    function automatic bit in_box(input int px, input int py, input int bx, input int by,
                                  input int w, input int h);
        return (px >= bx) && (px < bx + w) && (py >= by) && (py < by + h);
    endfunction

    function automatic bit rects_touch(input int ax, input int ay, input int aw, input int ah,
                                       input int bx, input int by, input int bw, input int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    // ---------------- behavioural model ----------------
    task automatic model_reset();
        m_mode = M_IDLE;
        m_x    = 0;
        m_y    = 0;
        m_left = 0;
        m_cyc  = 0;
        m_hit  = 0;
        m_rgb  = 0;
        samp_q.delete();
    endtask

    task automatic enter_cool();
        m_mode = M_COOL;
        m_y    = 0;
        m_left = COOL_TICKS;
    endtask

    task automatic model_step();
        bit tick, rise;
        int hx, vy;
        tick = ((m_cyc % MOVE_DIV) == MOVE_DIV - 1);
        // a press is a low sample followed by a high sample, both taken after reset
        rise = (samp_q.size() >= 3) && samp_q[$-1] && !samp_q[$-2];
        hx = int'(h_counter);
        vy = int'(v_counter);

        m_rgb = 0;
        if (vy > 2 && hx > 96) begin
            if (m_mode == M_FLY && in_box(hx, vy, m_x, m_y, SHOT_W, SHOT_LEN)) m_rgb = YELLOW;
`ifdef PLAYER_SHOT_FLASH_EN
            else if (m_mode == M_HIT && ((FLASH_TICKS - m_left) % 2 == 0) &&
                     in_box(hx, vy, int'(posX_enemy), int'(posY_enemy), ENEMY_W, ENEMY_H)) m_rgb = RED;
`endif
        end

        m_hit = 0;
        case (m_mode)
            M_IDLE: begin
                if (rise && int'(posY_player) >= Y_TOP + SHOT_LEN) begin
                    m_mode = M_FLY;
                    m_x    = int'(posX_player);
                    m_y    = int'(posY_player) - SHOT_LEN;
                end
            end
            M_FLY: begin
                if (rects_touch(m_x, m_y, SHOT_W, SHOT_LEN, int'(posX_enemy), int'(posY_enemy),
                                ENEMY_W, ENEMY_H)) begin
                    m_hit  = 1;
                    m_mode = M_HIT;
                    m_left = FLASH_TICKS;
                end else if (tick) begin
                    if (m_y - STEP < Y_TOP) enter_cool();
                    else m_y = m_y - STEP;
                end
            end
            M_HIT: begin
`ifdef PLAYER_SHOT_FLASH_EN
                if (tick) begin
                    m_left--;
                    if (m_left == 0) enter_cool();
                end
`else
                enter_cool();
`endif
            end
            default: begin
                if (tick) begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
        endcase

        samp_q.push_back(btn_fire);
        if (samp_q.size() > 3) void'(samp_q.pop_front());
        m_cyc++;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset && cmp_en) begin
            check("cyc_posX", int'(posX_shot), m_x);
            check("cyc_posY", int'(posY_shot), m_y);
            check("cyc_active", int'(shot_active), (m_mode == M_FLY) ? 1 : 0);
            check("cyc_hit", int'(hit), m_hit);
            check("cyc_rgb", int'({R, G, B}), m_rgb);
            check("cyc_state", int'(dbg_state), m_mode);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic launch(input int exp_x, input int exp_y);
        @(negedge clk);
        btn_fire = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("launch_not_early", int'(shot_active), 0);
        @(posedge clk);
        #1;
        check("launch_active", int'(shot_active), 1);
        check("launch_x", int'(posX_shot), exp_x);
        check("launch_y", int'(posY_shot), exp_y);
    endtask

    task automatic wait_y(input int target, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (int'(posY_shot) == target) break;
        end
        if (k == budget) check("wait_y_timeout", int'(posY_shot), target);
    endtask

    task automatic wait_inactive(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (!shot_active) break;
        end
        if (k == budget) check("wait_inactive_timeout", int'(shot_active), 0);
    endtask

    task automatic wait_hit(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (hit) break;
        end
        if (k == budget) check("wait_hit_timeout", int'(hit), 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        model_reset();
        #1 reset = 1'b1;
        #1;
        check("reset_posX", int'(posX_shot), 0);
        check("reset_posY", int'(posY_shot), 0);
        check("reset_active", int'(shot_active), 0);
        check("reset_hit", int'(hit), 0);
        check("reset_rgb", int'({R, G, B}), 0);
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        repeat (6) @(negedge clk);

        // flight 1: launch, held button, refire ignored, render, miss at the top
        launch(200, 284);
        repeat (4) @(posedge clk);
        #1 check("step_y", int'(posY_shot), 282);
        repeat (14) @(posedge clk);
        #1 btn_fire = 1'b0;
        posX_player = 11'd300;
        repeat (3) @(posedge clk);
        #1 btn_fire = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("refire_fly_x", int'(posX_shot), 200);
        btn_fire = 1'b0;

        wait_y(250, 200);
        h_counter = 10'd201;
        v_counter = 10'd260;
        @(posedge clk);
        #1 check("render_in_shot", int'({R, G, B}), YELLOW);
        h_counter = 10'd202;
        @(posedge clk);
        #1 check("render_right_of_shot", int'({R, G, B}), 0);
        h_counter = 10'd96;
        @(posedge clk);
        #1 check("render_hblank", int'({R, G, B}), 0);
        h_counter = 10'd0;
        v_counter = 10'd0;

        wait_y(4, 800);
        check("miss_top_y", int'(posY_shot), 4);
        wait_inactive(8);
        check("miss_cool_y", int'(posY_shot), 0);
        check("miss_cool_active", int'(shot_active), 0);
        btn_fire = 1'b1;
        repeat (4) @(posedge clk);
        #1 btn_fire = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("cool_refire_dropped", int'(shot_active), 0);

        // flight 2: relaunch at the blanking edge, then a hit landing on a tick cycle
        posX_player = 11'd96;
        launch(96, 284);
        h_counter = 10'd96;
        v_counter = 10'(m_y + 5);
        @(posedge clk);
        #1 check("render_col96_black", int'({R, G, B}), 0);
        h_counter = 10'd97;
        @(posedge clk);
        #1 check("render_col97_yellow", int'({R, G, B}), YELLOW);
        h_counter = 10'd0;
        v_counter = 10'd0;
        for (int k = 0; k < MOVE_DIV; k++) begin
            if ((m_cyc % MOVE_DIV) == MOVE_DIV - 1) break;
            @(posedge clk);
            #1;
        end
        y_prev = m_y;
        posX_enemy = 11'(m_x - 5);
        posY_enemy = 11'(m_y - 10);
        @(posedge clk);
        #1 check("tick_hit_pulse", int'(hit), 1);
        check("tick_hit_y_frozen", int'(posY_shot), y_prev);
        posX_enemy = 11'd600;
        posY_enemy = 11'd0;
        repeat (40) @(posedge clk);

        // flight 3: asynchronous reset mid-flight with the button held through release
        @(negedge clk);
        btn_fire = 1'b0;
        posX_player = 11'd200;
        repeat (3) @(negedge clk);
        launch(200, 284);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midreset_posX", int'(posX_shot), 0);
        check("midreset_posY", int'(posY_shot), 0);
        check("midreset_active", int'(shot_active), 0);
        check("midreset_rgb", int'({R, G, B}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("held_fire_no_launch", int'(shot_active), 0);

        // flight 4: hit on the enemy box at Y=222
        @(negedge clk);
        btn_fire = 1'b0;
        posX_enemy = 11'd190;
        posY_enemy = 11'd200;
        repeat (3) @(negedge clk);
        launch(200, 284);
        h_counter = 10'd195;
        v_counter = 10'd205;
        wait_hit(400);
        check("hit_y", int'(posY_shot), 222);
        check("hit_x", int'(posX_shot), 200);
        check("hit_active", int'(shot_active), 0);
        @(posedge clk);
        #1 check("hit_one_cycle", int'(hit), 0);
`ifdef PLAYER_SHOT_FLASH_EN
        check("hit_y_hold", int'(posY_shot), 222);
        check("hit_flash_red", int'({R, G, B}), RED);
`else
        check("hit_y_cleared", int'(posY_shot), 0);
        check("hit_no_flash", int'({R, G, B}), 0);
`endif
        wait_y(0, 40);
        repeat (20) @(posedge clk);
        btn_fire = 1'b0;
        h_counter = 10'd0;
        v_counter = 10'd0;
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
